// File: rtl/vedic_mult_signed_pipe.sv
// rtl/vedic_mult_signed_pipe.sv - 3-stage pipelined signed/unsigned Urdhva-Tiryagbhyam multiplier
`timescale 1ns/1ps

// Parallel-prefix (Kogge-Stone) carry adder; carry-in is folded into bit 0's generate.
module vedic_cla_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_half;
    logic [W-2:0] w_g;
    logic [W-2:0] w_p;
    logic [W-2:0] w_gn;
    logic [W-2:0] w_pn;

    always_comb begin
        w_half = i_a ^ i_b;
        w_g    = i_a[W-2:0] & i_b[W-2:0];
        w_p    = w_half[W-2:0];
        w_g[0] = w_g[0] | (w_p[0] & i_cin);
        w_p[0] = 1'b0;
        w_gn   = w_g;
        w_pn   = w_p;
        for (int d = 1; d < W - 1; d = d * 2) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = d; i < W - 1; i++) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i-d]);
                w_pn[i] = w_p[i] & w_p[i-d];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        // w_g[i] is now the carry out of bit i, i.e. the carry into bit i+1.
        o_sum = w_half ^ {w_g, i_cin};
    end

endmodule

// Half-width vedic block: one more Urdhva split into quarter-width cross products.
module vedic_mult_half #(
    parameter int H = 16
) (
    input  logic [H-1:0]   i_a,
    input  logic [H-1:0]   i_b,
    output logic [2*H-1:0] o_p
);

    localparam int Q = H / 2;

    logic [H-1:0] w_ll;
    logic [H-1:0] w_lh;
    logic [H-1:0] w_hl;
    logic [H-1:0] w_hh;
    logic [H:0]   w_mid;

    assign w_ll  = {{Q{1'b0}}, i_a[Q-1:0]} * {{Q{1'b0}}, i_b[Q-1:0]};
    assign w_lh  = {{Q{1'b0}}, i_a[Q-1:0]} * {{Q{1'b0}}, i_b[H-1:Q]};
    assign w_hl  = {{Q{1'b0}}, i_a[H-1:Q]} * {{Q{1'b0}}, i_b[Q-1:0]};
    assign w_hh  = {{Q{1'b0}}, i_a[H-1:Q]} * {{Q{1'b0}}, i_b[H-1:Q]};
    assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
    assign o_p   = {w_hh, w_ll} + {{(Q-1){1'b0}}, w_mid, {Q{1'b0}}};

endmodule

module vedic_mult_signed_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;

    logic               r_s1_valid;
    logic               r_s1_sign;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    logic               r_s2_sign;
    logic [WIDTH-1:0]   r_s2_ll;
    logic [WIDTH-1:0]   r_s2_lh;
    logic [WIDTH-1:0]   r_s2_hl;
    logic [WIDTH-1:0]   r_s2_hh;
    logic [TAG_W-1:0]   r_s2_tag;

    logic               r_s3_valid;
    logic [W2-1:0]      r_s3_prod;
    logic [TAG_W-1:0]   r_s3_tag;

    logic               w_stall;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_ll;
    logic [WIDTH-1:0]   w_lh;
    logic [WIDTH-1:0]   w_hl;
    logic [WIDTH-1:0]   w_hh;
    logic [WIDTH:0]     w_mid;
    logic [W2-1:0]      w_mag;
    logic [W2-1:0]      w_res;

    // Global stall: a product waiting at the output freezes every stage.
    assign w_stall   = r_s3_valid & ~out_ready;
    assign in_ready  = rst_n & ~w_stall;
    assign out_valid = r_s3_valid;
    assign out_prod  = r_s3_prod;
    assign out_tag   = r_s3_tag;

    assign w_neg_a = in_signed & in_a[WIDTH-1];
    assign w_neg_b = in_signed & in_b[WIDTH-1];

    // Magnitude via invert-and-increment; -2^(W-1) maps onto 2^(W-1) unsigned.
    vedic_cla_adder #(.W(WIDTH)) u_abs_a (
        .i_a   (in_a ^ {WIDTH{w_neg_a}}),
        .i_b   ('0),
        .i_cin (w_neg_a),
        .o_sum (w_abs_a)
    );

    vedic_cla_adder #(.W(WIDTH)) u_abs_b (
        .i_a   (in_b ^ {WIDTH{w_neg_b}}),
        .i_b   ('0),
        .i_cin (w_neg_b),
        .o_sum (w_abs_b)
    );

    vedic_mult_half #(.H(H)) u_pp_ll (.i_a(r_s1_a[H-1:0]),     .i_b(r_s1_b[H-1:0]),     .o_p(w_ll));
    vedic_mult_half #(.H(H)) u_pp_lh (.i_a(r_s1_a[H-1:0]),     .i_b(r_s1_b[WIDTH-1:H]), .o_p(w_lh));
    vedic_mult_half #(.H(H)) u_pp_hl (.i_a(r_s1_a[WIDTH-1:H]), .i_b(r_s1_b[H-1:0]),     .o_p(w_hl));
    vedic_mult_half #(.H(H)) u_pp_hh (.i_a(r_s1_a[WIDTH-1:H]), .i_b(r_s1_b[WIDTH-1:H]), .o_p(w_hh));

    // Cross-term sum keeps its carry (WIDTH+1 bits) so no product bit is dropped.
    vedic_cla_adder #(.W(WIDTH + 1)) u_mid (
        .i_a   ({1'b0, r_s2_lh}),
        .i_b   ({1'b0, r_s2_hl}),
        .i_cin (1'b0),
        .o_sum (w_mid)
    );

    vedic_cla_adder #(.W(W2)) u_sum (
        .i_a   ({r_s2_hh, r_s2_ll}),
        .i_b   ({{(H-1){1'b0}}, w_mid, {H{1'b0}}}),
        .i_cin (1'b0),
        .o_sum (w_mag)
    );

    vedic_cla_adder #(.W(W2)) u_neg (
        .i_a   (w_mag ^ {W2{r_s2_sign}}),
        .i_b   ('0),
        .i_cin (r_s2_sign),
        .o_sum (w_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_ll    <= '0;
            r_s2_lh    <= '0;
            r_s2_hl    <= '0;
            r_s2_hh    <= '0;
            r_s2_tag   <= '0;
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
            r_s3_tag   <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                r_s1_a    <= w_abs_a;
                r_s1_b    <= w_abs_b;
                r_s1_tag  <= in_tag;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_ll   <= w_ll;
                r_s2_lh   <= w_lh;
                r_s2_hl   <= w_hl;
                r_s2_hh   <= w_hh;
                r_s2_tag  <= r_s1_tag;
            end
            // Bubbles leave the output data untouched so it keeps its last value.
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_prod <= w_res;
                r_s3_tag  <= r_s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_vedic_mult_signed_pipe.sv
// tb/tb_vedic_mult_signed_pipe.sv - scoreboard bench for vedic_mult_signed_pipe at WIDTH=32
`timescale 1ns/1ps

module tb_vedic_mult_signed_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [2*WIDTH-1:0] prod;
        logic [TAG_W-1:0]   tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic [TAG_W-1:0]   out_tag;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    always #5 clk = ~clk;

    vedic_mult_signed_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag)
    );

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (sgn) begin
            sa  = $signed({{32{a[31]}}, a});
            sbv = $signed({{32{b[31]}}, b});
            return sa * sbv;
        end
        return $unsigned({32'd0, a}) * $unsigned({32'd0, b});
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got prod=%h tag=%h, required no output", out_prod, out_tag);
            end else begin
                mon_e = sb.pop_front();
                n_popped++;
                if (out_prod !== mon_e.prod) begin
                    n_err++;
                    $display("FAIL out_prod: got %h required %h", out_prod, mon_e.prod);
                end
                n_cmp++;
                if (out_tag !== mon_e.tag) begin
                    n_err++;
                    $display("FAIL out_tag: got %h required %h", out_tag, mon_e.tag);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send_exp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic [3:0] tag, input logic [63:0] exp_prod);
        logic rdy;
        int   budget;
        bit   done;
        budget = 0;
        done   = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        in_tag    = tag;
        while (!done) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back('{prod: exp_prod, tag: tag});
                n_pushed++;
                done = 1;
            end else if (++budget > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
                done = 1;
            end
        end
        #1;
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic sgn, input logic [3:0] tag);
        send_exp(a, b, sgn, tag, model(a, b, sgn));
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (out_prod !== 64'd0) begin n_err++; $display("FAIL reset_out_prod: got %h required 0", out_prod); end
        n_cmp++; if (out_tag !== 4'd0) begin n_err++; $display("FAIL reset_out_tag: got %h required 0", out_tag); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] vb [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h80000000, 32'h00000001};
        logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] ve [6] = '{64'hFFFFFFFE_00000001, 64'h00000000_00000001, 64'hFFFFFFFF_FFFFFFF1,
                                64'h40000000_00000000, 64'h40000000_00000000, 64'hFFFFFFFF_80000000};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_exp(va[i], vb[i], vs[i], 4'(i + 1), ve[i]);
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early[%0d]: got out_valid=%b required 0", i, out_valid); end
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_3[%0d]: got out_valid=%b required 1", i, out_valid); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  hist;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          not_ready;
        not_ready = 0;
        hist = '0;
        out_ready = 1'b1;
        a = $urandom; b = $urandom; s = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = 4'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hist[k] = out_valid;
            if (k < 4 && in_ready !== 1'b1) not_ready++;
            @(posedge clk);
            if (k < 4) begin
                sb.push_back('{prod: model(a, b, s), tag: 4'(k + 1)});
                n_pushed++;
            end
            #1;
            if (k + 1 < 4) begin
                a = $urandom; b = $urandom; s = ~s;
                in_a = a; in_b = b; in_signed = s; in_tag = 4'(k + 2);
            end else begin
                in_valid = 1'b0;
            end
        end
        n_cmp++; if (not_ready != 0) begin n_err++; $display("FAIL b2b_in_ready: got %0d not-ready cycles required 0", not_ready); end
        n_cmp++; if (hist !== 10'b0001111000) begin n_err++; $display("FAIL b2b_valid_pattern: got %b required 0001111000", hist); end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  t;
        int          sent;
        int          cyc;
        logic        rdy;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'(i), 4'(8 + i));
        in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h8765_4321; in_signed = 1'b1; in_tag = 4'hB;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b required 0", k, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %b required 1", k, out_valid); end
            n_cmp++; if (out_prod !== sb[0].prod) begin n_err++; $display("FAIL stall_prod_hold[%0d]: got %h required %h", k, out_prod, sb[0].prod); end
            n_cmp++; if (out_tag !== sb[0].tag) begin n_err++; $display("FAIL stall_tag_hold[%0d]: got %h required %h", k, out_tag, sb[0].tag); end
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        send_beat(32'h1234_5678, 32'h8765_4321, 1'b1, 4'hB);
        in_valid = 1'b0;
        sent = 0;
        cyc  = 0;
        while ((sent < 24 || sb.size() != 0) && cyc < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 24 && $urandom_range(0, 3) != 0) begin
                a = $urandom; b = $urandom; s = 1'($urandom); t = 4'($urandom);
                if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
                in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
            end
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) begin
                sb.push_back('{prod: model(a, b, s), tag: t});
                n_pushed++;
                sent++;
                #1 in_valid = 1'b0;
            end else begin
                #1;
            end
            cyc++;
        end
        out_ready = 1'b1;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL drain: got %0d products outstanding required 0", sb.size()); end
        n_cmp++; if (n_popped != n_pushed) begin n_err++; $display("FAIL beat_count: got %0d out required %0d", n_popped, n_pushed); end
    endtask

    task automatic test_reset_inflight();
        int early;
        early = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat($urandom, $urandom, 1'b1, 4'(3 + i));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flight_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_flight_in_ready: got %b required 0", in_ready); end
        n_cmp++; if (out_tag !== 4'd0) begin n_err++; $display("FAIL rst_flight_out_tag: got %h required 0", out_tag); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) early++;
            @(posedge clk);
        end
        #1;
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL stale_after_reset: got %0d valid cycles required 0", early); end
        send_exp(32'hFFFF_FFF9, 32'h0000_0007, 1'b1, 4'hE, 64'hFFFFFFFF_FFFFFFCF);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_latency: got out_valid=%b required 1", out_valid); end
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL post_reset_drain: got %0d outstanding required 0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
